muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RV32M operations; sits beside the single-cycle ALU in the execute stage.
- Takes the same SrcA/SrcB operands and a 3-bit funct3 operation code.
- Controller stalls the datapath while Busy=1 and captures MDResult on Done.
- Processes one bit per cycle: shift-add for multiply, restoring division for divide.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on magnitudes.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         is_div_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] lo_o
);

  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    sh   = {acc_i, lo_i[W-1]};
    ge   = sh >= {1'b0, b_i};
    // ge guarantees the true difference fits in W bits
    diff = sh[W-1:0] - b_i;
    if (is_div_i) begin
      acc_o = ge ? diff : sh[W-1:0];
      lo_o  = {lo_i[W-2:0], ge};
    end else begin
      acc_o = sum[W:1];
      lo_o  = {sum[0], lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle beside the ALU.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    MDResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] Q_ONES = '1;
  localparam logic [W-1:0] S_MIN  = {1'b1, {(W-1){1'b0}}};

  md_state_e      state_q, state_d;
  md_op_e         op_q, op_d;
  logic           neg_q, neg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;

  md_op_e         op_in;
  logic           a_sgn, b_sgn, a_neg, b_neg;
  logic           in_div, in_rem, div0, ovf;
  logic [W-1:0]   a_mag, b_mag;
  logic           is_div;
  logic [W-1:0]   st_acc, st_lo;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quot_s, rem_s, fin;

  always_comb begin
    op_in  = md_op_e'(Operation);
    a_sgn  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg  = a_sgn & SrcA[W-1];
    b_neg  = b_sgn & SrcB[W-1];
    a_mag  = a_neg ? -SrcA : SrcA;
    b_mag  = b_neg ? -SrcB : SrcB;
    in_div = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    in_rem = op_in inside {OP_REM, OP_REMU};
    div0   = in_div && (SrcB == '0);
    ovf    = (op_in inside {OP_DIV, OP_REM}) &&
             (SrcA == S_MIN) && (SrcB == Q_ONES);
    is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  end

  muldiv_step #(.W(W)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .acc_o    (st_acc),
    .lo_o     (st_lo)
  );

  always_comb begin
    prod   = {st_acc, st_lo};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -st_lo : st_lo;
    rem_s  = neg_q ? -st_acc : st_acc;
    unique case (op_q)
      OP_MUL:                       fin = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:              fin = quot_s;
      default:                      fin = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d  = op_in;
          cnt_d = CW'(W);
          acc_d = '0;
          lo_d  = in_div ? a_mag : b_mag;
          b_d   = in_div ? b_mag : a_mag;
          // remainder follows the dividend, everything else the xor
          neg_d = (in_rem) ? a_neg : (a_neg ^ b_neg);
          if (div0) begin
            res_d   = in_rem ? SrcA : Q_ONES;
            state_d = S_DONE;
          end else if (ovf) begin
            res_d   = in_rem ? '0 : S_MIN;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = st_acc;
        lo_d  = st_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_d   = fin;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign Busy     = (state_q == S_CALC);
  assign Done     = (state_q == S_DONE);
  assign MDResult = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] MDResult;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .MDResult  (MDResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for Done, counting cycles since accept and Busy cycles.
  task automatic wait_done(inout int n, output int bz);
    bz = 0;
    while (!Done && n < 60) begin
      if (Busy) bz++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input md_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input int lat, input string tag);
    int n;
    int bz;
    @(negedge clk);
    Start = 1'b1;
    Operation = op;
    SrcA = a;
    SrcB = b;
    @(negedge clk);
    Start = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
    n = 1;
    wait_done(n, bz);
    chk({tag, " done"}, 32'(Done), 32'd1);
    chk({tag, " lat"}, n, lat);
    chk({tag, " busy"}, bz, lat - 1);
    chk({tag, " res"}, MDResult, exp);
  endtask

  initial begin
    int n;
    int bz;
    reset = 1'b0;
    Start = 1'b0;
    Operation = 3'b000;
    SrcA = '0;
    SrcB = '0;
    #12;
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst res", MDResult, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run(OP_MUL,    32'd7,         32'd6,         32'd42,        33, "mul 7*6");
    run(OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  33, "mulh -1*-1");
    run(OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33, "mulhu max");
    run(OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  33, "mulhsu");
    run(OP_MUL,    32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  33, "mul -3*5");
    run(OP_MULH,   32'h80000000,  32'h80000000,  32'h40000000,  33, "mulh min*min");
    run(OP_DIV,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33, "div -7/2");
    run(OP_REM,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33, "rem -7/2");
    run(OP_DIV,    32'd20,        32'hFFFFFFFA,  32'hFFFFFFFD,  33, "div 20/-6");
    run(OP_REM,    32'd20,        32'hFFFFFFFA,  32'd2,         33, "rem 20/-6");
    run(OP_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu 100/7");
    run(OP_REMU,   32'd100,       32'd7,         32'd2,         33, "remu 100/7");
    run(OP_DIVU,   32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  33, "divu max/1");
    run(OP_DIVU,   32'd5,         32'd0,         32'hFFFFFFFF,  1,  "divu 5/0");
    run(OP_REM,    32'd5,         32'd0,         32'd5,         1,  "rem 5/0");
    run(OP_DIV,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  "div ovf");
    run(OP_REM,    32'h80000000,  32'hFFFFFFFF,  32'd0,         1,  "rem ovf");

    // Start re-pulsed during CALC must be ignored
    @(negedge clk);
    Start = 1'b1;
    Operation = OP_DIVU;
    SrcA = 32'd100;
    SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    n = 1;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    Start = 1'b1;
    Operation = OP_MUL;
    SrcA = 32'd5;
    SrcB = 32'd5;
    @(negedge clk);
    n++;
    Start = 1'b0;
    wait_done(n, bz);
    chk("calc ign lat", n, 33);
    chk("calc ign res", MDResult, 32'd14);

    // Start during DONE is ignored, Done is a single-cycle pulse
    Start = 1'b1;
    Operation = OP_MUL;
    SrcA = 32'd2;
    SrcB = 32'd2;
    @(negedge clk);
    Start = 1'b0;
    chk("done pulse", 32'(Done), 32'd0);
    @(negedge clk);
    chk("done ign busy", 32'(Busy), 32'd0);
    chk("done ign done", 32'(Done), 32'd0);
    chk("done ign res", MDResult, 32'd14);

    // Back-to-back: second op started the cycle after Done
    run(OP_MUL,    32'd11,        32'd13,        32'd143,       33, "b2b first");
    run(OP_REMU,   32'd50,        32'd8,         32'd2,         33, "b2b second");

    // Reset mid-DIV aborts immediately
    @(negedge clk);
    Start = 1'b1;
    Operation = OP_DIV;
    SrcA = 32'd1000;
    SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre rst busy", 32'(Busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid rst busy", 32'(Busy), 32'd0);
    chk("mid rst done", 32'(Done), 32'd0);
    chk("mid rst res", MDResult, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run(OP_MUL,    32'd3,         32'd3,         32'd9,         33, "post rst mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
